inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter PC_W, default 16, meaning program-counter and instruction-memory address width.
REQ-002 The block SHALL have parameter HALT_OP, default 5'b11011, meaning the oper_type value (IR[31:27]) that stops fetching.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port sys_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port imem_en, output, 1 bit: instruction-memory read strobe.
REQ-006 Port imem_addr, output, PC_W bits: instruction-memory read address.
REQ-007 Port imem_rdata, input, 32 bits: memory read data, valid exactly one cycle after imem_en is sampled high.
REQ-008 Port ir, output, 32 bits: fetched instruction word presented to the execute stage.
REQ-009 Port ir_pc, output, PC_W bits: address from which ir was fetched.
REQ-010 Port ir_valid, output, 1 bit: ir holds an instruction not yet accepted.
REQ-011 Port ir_ready, input, 1 bit: execute stage accepts ir when ir_valid and ir_ready are both high on a rising edge.
REQ-012 Port jmp_valid, input, 1 bit: redirect request.
REQ-013 Port jmp_addr, input, PC_W bits: redirect target.
REQ-014 Port halted, output, 1 bit: fetch has stopped on HALT_OP.

Function
REQ-015 The block SHALL implement four states: REQ, LOAD, VALID, HALT.
REQ-016 In REQ, the block SHALL drive imem_en=1 and imem_addr=pc, then move to LOAD.
REQ-017 In LOAD, the block SHALL perform all of the following on the edge, then move to VALID:
- capture imem_rdata into ir;
- set ir_pc to pc;
- increment pc by 1;
- set ir_valid to 1.
REQ-018 imem_en SHALL be 0 in every state other than REQ; imem_addr SHALL always equal pc.
REQ-019 In VALID, ir and ir_pc SHALL be held stable while ir_ready=0.
REQ-020 In VALID with ir_ready=1, the block SHALL clear ir_valid; it SHALL move to HALT if ir[31:27]==HALT_OP, otherwise to REQ.
REQ-021 Minimum issue interval SHALL be 3 cycles per instruction (REQ, LOAD, VALID with ir_ready=1).
REQ-022 pc increment SHALL wrap modulo 2^PC_W (all-ones -> 0) with no error indication.
REQ-023 jmp_valid=1 in REQ, LOAD or VALID SHALL have priority over all other events, and on that edge the block SHALL:
- load pc with jmp_addr;
- clear ir_valid;
- discard any in-flight imem_rdata;
- move to REQ.
REQ-024 jmp_valid coincident with an ir_valid/ir_ready handshake SHALL still complete the handshake; the redirect SHALL win the next-state decision, including over HALT_OP.
REQ-025 In HALT, the block SHALL drive halted=1, ir_valid=0 and imem_en=0, and SHALL ignore jmp_valid and ir_ready until reset.
REQ-026 halted SHALL be 1 only in HALT.

Reset
REQ-027 While sys_rst=0, the block SHALL hold the following values immediately, independent of clk:
- state=REQ, pc=0;
- ir=0, ir_pc=0, ir_valid=0;
- halted=0.
REQ-028 Reset assertion in any state, including mid-LOAD or HALT, SHALL abort the fetch and discard memory data.
REQ-029 After sys_rst deasserts, the first rising edge SHALL occur in REQ with imem_en=1 and imem_addr=0.

Verification
REQ-030 Straight-line fetch: memory word0=32'h1080_0004, word1=32'h1100_0037, ir_ready=1 throughout -> ir=32'h1080_0004 with ir_pc=0 accepted, then 32'h1100_0037 with ir_pc=1, 3 cycles apart.
REQ-031 Back-pressure: ir_ready=0 for 5 cycles after ir_valid rises -> ir, ir_pc and ir_valid stable, imem_en=0 throughout, next fetch from pc+1 after ir_ready=1.
REQ-032 Redirect: jmp_valid=1 with jmp_addr=16'h0020 during LOAD -> no ir_valid for the discarded word; next imem_addr=16'h0020; next ir_pc=16'h0020.
REQ-033 Halt: word at address 2 = 32'hD800_0000 (oper_type 5'b11011) -> accepted once, then halted=1, imem_en=0, and jmp_valid ignored for 10 cycles.
REQ-034 Wrap: jmp_addr=16'hFFFF -> instruction fetched with ir_pc=16'hFFFF, next ir_pc=16'h0000.
REQ-035 Async reset: sys_rst=0 asserted mid-VALID between clock edges -> ir_valid=0, ir=0 and pc=0 before the next edge; fetch restarts at address 0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: requests a word from instruction memory, presents it to
// execute with a valid/ready handshake, follows redirects and stops on the halt opcode.
module inst_fetch #(
   parameter int unsigned PC_W    = 16,
   parameter logic [4:0]  HALT_OP = 5'b11011
) (
   input  logic            clk,
   input  logic            sys_rst,
   output logic            imem_en,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     ir,
   output logic [PC_W-1:0] ir_pc,
   output logic            ir_valid,
   input  logic            ir_ready,
   input  logic            jmp_valid,
   input  logic [PC_W-1:0] jmp_addr,
   output logic            halted
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_LOAD  = 2'd1,
      S_VALID = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc, pc_nxt;
   logic [31:0]       ir_nxt;
   logic [PC_W-1:0]   ir_pc_nxt;
   logic              ir_valid_nxt;

   // Next-state and datapath update; a redirect overrides everything except HALT.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      ir_nxt       = ir;
      ir_pc_nxt    = ir_pc;
      ir_valid_nxt = ir_valid;
      case (state)
         S_REQ: begin
            state_nxt = S_LOAD;
         end
         S_LOAD: begin
            ir_nxt       = imem_rdata;
            ir_pc_nxt    = pc;
            pc_nxt       = pc + PC_W'(1);
            ir_valid_nxt = 1'b1;
            state_nxt    = S_VALID;
         end
         S_VALID: begin
            if (ir_ready) begin
               ir_valid_nxt = 1'b0;
               state_nxt    = (ir[31:27] == HALT_OP) ? S_HALT : S_REQ;
            end
         end
         S_HALT: begin
            ir_valid_nxt = 1'b0;
         end
         default: begin
            state_nxt = S_REQ;
         end
      endcase
      if (jmp_valid && (state != S_HALT)) begin
         // In-flight memory data is dropped by keeping the old ir/ir_pc.
         ir_nxt       = ir;
         ir_pc_nxt    = ir_pc;
         pc_nxt       = jmp_addr;
         ir_valid_nxt = 1'b0;
         state_nxt    = S_REQ;
      end
   end

   // State and registered outputs; strobes are decoded from the next state.
   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state    <= S_REQ;
         pc       <= '0;
         ir       <= '0;
         ir_pc    <= '0;
         ir_valid <= 1'b0;
         imem_en  <= 1'b1;
         halted   <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         ir       <= ir_nxt;
         ir_pc    <= ir_pc_nxt;
         ir_valid <= ir_valid_nxt;
         imem_en  <= (state_nxt == S_REQ);
         halted   <= (state_nxt == S_HALT);
      end
   end

   assign imem_addr = pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run
// against an address-level reference model of the fetch stream.
module tb_inst_fetch;
   localparam int unsigned PC_W = 16;

   logic            clk = 1'b0;
   logic            sys_rst = 1'b0;
   logic            imem_en;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic [31:0]     ir;
   logic [PC_W-1:0] ir_pc;
   logic            ir_valid;
   logic            ir_ready = 1'b0;
   logic            jmp_valid = 1'b0;
   logic [PC_W-1:0] jmp_addr = '0;
   logic            halted;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [logic [15:0]];

   inst_fetch #(.PC_W(PC_W), .HALT_OP(5'b11011)) dut (
      .clk(clk), .sys_rst(sys_rst), .imem_en(imem_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .jmp_valid(jmp_valid), .jmp_addr(jmp_addr), .halted(halted)
   );

   always #5 clk = ~clk;

   // Default contents never carry the halt opcode (bit 31 clear).
   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return {1'b0, 15'(a), a ^ 16'hA5C3};
   endfunction

   always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_valid(output int c);
      c = 0;
      while (ir_valid !== 1'b1 && c < 20) begin
         step();
         c++;
      end
      if (ir_valid !== 1'b1) c = -1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      sys_rst = 1'b0; jmp_valid = 1'b0; ir_ready = 1'b0;
      #2;
      @(negedge clk);
      sys_rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      sys_rst = 1'b0;
      step();
      total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rst_ir_valid got=%b exp=0", ir_valid); end
      total++; if (ir !== 32'h0) begin bad++; $display("FAIL rst_ir got=%h exp=0", ir); end
      total++; if (ir_pc !== 16'h0) begin bad++; $display("FAIL rst_ir_pc got=%h exp=0", ir_pc); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
      sys_rst = 1'b1;
      total++; if (imem_en !== 1'b1) begin bad++; $display("FAIL rst_imem_en got=%b exp=1", imem_en); end
      total++; if (imem_addr !== 16'h0) begin bad++; $display("FAIL rst_imem_addr got=%h exp=0", imem_addr); end
   endtask

   task automatic test_straight();
      int c;
      mem[16'd0] = 32'h1080_0004;
      mem[16'd1] = 32'h1100_0037;
      apply_reset();
      ir_ready = 1'b1;
      wait_valid(c);
      total++; if (c !== 2) begin bad++; $display("FAIL straight_lat0 got=%0d exp=2", c); end
      total++; if (ir !== 32'h1080_0004) begin bad++; $display("FAIL straight_ir0 got=%h exp=10800004", ir); end
      total++; if (ir_pc !== 16'h0) begin bad++; $display("FAIL straight_pc0 got=%h exp=0", ir_pc); end
      total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL straight_en0 got=%b exp=0", imem_en); end
      step();
      wait_valid(c);
      total++; if (c + 1 !== 3) begin bad++; $display("FAIL straight_interval got=%0d exp=3", c + 1); end
      total++; if (ir !== 32'h1100_0037) begin bad++; $display("FAIL straight_ir1 got=%h exp=11000037", ir); end
      total++; if (ir_pc !== 16'h1) begin bad++; $display("FAIL straight_pc1 got=%h exp=1", ir_pc); end
      step();
      total++; if (imem_addr !== 16'h2) begin bad++; $display("FAIL straight_next got=%h exp=2", imem_addr); end
   endtask

   task automatic test_backpressure();
      int c;
      apply_reset();
      ir_ready = 1'b1;
      wait_valid(c);
      step();
      ir_ready = 1'b0;
      wait_valid(c);
      total++; if (c !== 2) begin bad++; $display("FAIL bp_lat got=%0d exp=2", c); end
      for (int k = 0; k < 5; k++) begin
         step();
         total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, ir_valid); end
         total++; if (ir !== mem_word(16'd1)) begin bad++; $display("FAIL bp_ir[%0d] got=%h exp=%h", k, ir, mem_word(16'd1)); end
         total++; if (ir_pc !== 16'd1) begin bad++; $display("FAIL bp_pc[%0d] got=%h exp=1", k, ir_pc); end
         total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL bp_en[%0d] got=%b exp=0", k, imem_en); end
      end
      ir_ready = 1'b1;
      step();
      total++; if (imem_en !== 1'b1) begin bad++; $display("FAIL bp_refetch_en got=%b exp=1", imem_en); end
      total++; if (imem_addr !== 16'd2) begin bad++; $display("FAIL bp_refetch_addr got=%h exp=2", imem_addr); end
   endtask

   task automatic test_redirect();
      int c;
      apply_reset();
      ir_ready = 1'b1;
      step();
      jmp_valid = 1'b1; jmp_addr = 16'h0020;
      step();
      jmp_valid = 1'b0;
      total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL jmp_valid_drop got=%b exp=0", ir_valid); end
      total++; if (imem_en !== 1'b1) begin bad++; $display("FAIL jmp_en got=%b exp=1", imem_en); end
      total++; if (imem_addr !== 16'h0020) begin bad++; $display("FAIL jmp_addr got=%h exp=0020", imem_addr); end
      wait_valid(c);
      total++; if (c !== 2) begin bad++; $display("FAIL jmp_lat got=%0d exp=2", c); end
      total++; if (ir_pc !== 16'h0020) begin bad++; $display("FAIL jmp_ir_pc got=%h exp=0020", ir_pc); end
      total++; if (ir !== mem_word(16'h0020)) begin bad++; $display("FAIL jmp_ir got=%h exp=%h", ir, mem_word(16'h0020)); end
      step();
   endtask

   task automatic test_wrap();
      int c;
      apply_reset();
      ir_ready = 1'b1;
      jmp_valid = 1'b1; jmp_addr = 16'hFFFF;
      step();
      jmp_valid = 1'b0;
      wait_valid(c);
      total++; if (ir_pc !== 16'hFFFF) begin bad++; $display("FAIL wrap_pc0 got=%h exp=ffff", ir_pc); end
      total++; if (ir !== mem_word(16'hFFFF)) begin bad++; $display("FAIL wrap_ir0 got=%h exp=%h", ir, mem_word(16'hFFFF)); end
      step();
      wait_valid(c);
      total++; if (ir_pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc1 got=%h exp=0000", ir_pc); end
      total++; if (ir !== mem_word(16'h0000)) begin bad++; $display("FAIL wrap_ir1 got=%h exp=%h", ir, mem_word(16'h0000)); end
      step();
   endtask

   task automatic test_halt();
      int c;
      mem[16'd2] = 32'hD800_0000;
      apply_reset();
      ir_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wait_valid(c);
         step();
      end
      wait_valid(c);
      total++; if (ir !== 32'hD800_0000) begin bad++; $display("FAIL halt_ir got=%h exp=d8000000", ir); end
      total++; if (ir_pc !== 16'd2) begin bad++; $display("FAIL halt_ir_pc got=%h exp=2", ir_pc); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", halted); end
      step();
      for (int k = 0; k < 10; k++) begin
         jmp_valid = 1'b1; jmp_addr = 16'($urandom); ir_ready = 1'($urandom);
         total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag[%0d] got=%b exp=1", k, halted); end
         total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL halt_en[%0d] got=%b exp=0", k, imem_en); end
         total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL halt_valid[%0d] got=%b exp=0", k, ir_valid); end
         total++; if (imem_addr !== 16'd3) begin bad++; $display("FAIL halt_pc[%0d] got=%h exp=3", k, imem_addr); end
         step();
      end
      jmp_valid = 1'b0;
      #2 sys_rst = 1'b0;
      #1;
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_rst got=%b exp=0", halted); end
      total++; if (imem_addr !== 16'd0) begin bad++; $display("FAIL halt_rst_pc got=%h exp=0", imem_addr); end
      @(negedge clk);
      sys_rst = 1'b1;
      mem.delete(16'd2);
   endtask

   task automatic test_async_reset();
      int c;
      apply_reset();
      ir_ready = 1'b0;
      wait_valid(c);
      #2 sys_rst = 1'b0;
      #1;
      total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", ir_valid); end
      total++; if (ir !== 32'h0) begin bad++; $display("FAIL arst_ir got=%h exp=0", ir); end
      total++; if (imem_addr !== 16'h0) begin bad++; $display("FAIL arst_pc got=%h exp=0", imem_addr); end
      @(negedge clk);
      sys_rst = 1'b1;
      ir_ready = 1'b1;
      total++; if (imem_en !== 1'b1 || imem_addr !== 16'h0) begin bad++; $display("FAIL arst_restart got=%b/%h exp=1/0000", imem_en, imem_addr); end
      wait_valid(c);
      total++; if (c !== 2 || ir_pc !== 16'h0) begin bad++; $display("FAIL arst_refetch got=%0d/%h exp=2/0000", c, ir_pc); end
      step();
   endtask

   // Model: exp is the address of the next instruction the stream must deliver.
   task automatic test_random();
      logic [15:0] exp;
      logic        v, rdy, jv;
      logic [15:0] ja;
      int          accepted = 0;
      apply_reset();
      exp = 16'h0;
      for (int k = 0; k < 400; k++) begin
         rdy = (($urandom % 10) < 7);
         jv  = (($urandom % 12) == 0);
         ja  = 16'($urandom);
         ir_ready = rdy; jmp_valid = jv; jmp_addr = ja;
         v = ir_valid;
         if (v) begin
            total++; if (ir !== mem_word(exp) || ir_pc !== exp) begin bad++; $display("FAIL rnd_ir[%0d] got=%h@%h exp=%h@%h", k, ir, ir_pc, mem_word(exp), exp); end
         end
         if (imem_en) begin
            total++; if (imem_addr !== exp || v) begin bad++; $display("FAIL rnd_req[%0d] got=%h/%b exp=%h/0", k, imem_addr, v, exp); end
         end
         total++; if (halted !== 1'b0) begin bad++; $display("FAIL rnd_halted[%0d] got=%b exp=0", k, halted); end
         if (v && rdy) accepted++;
         if (jv) exp = ja;
         else if (v && rdy) exp = exp + 16'd1;
         step();
      end
      jmp_valid = 1'b0;
      total++; if (accepted < 40) begin bad++; $display("FAIL rnd_progress got=%0d exp>=40", accepted); end
   endtask

   initial begin
      test_reset();
      test_straight();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
